player_key_conditioner: RTL and testbench

Conditions the four raw active-low pushbuttons before they reach the reaction-game controller. Per key it synchronises, debounces on the 1 ms tick, and provides a clean level and a one-cycle press pulse. For the player keys (key 0 = player 1, key 3 = player 2) it also performs first-press arbitration inside an armed window and reports the winner (or a tie) to the controller.

---
 rtl/player_key_conditioner_pkg.sv | 36 +++
 rtl/player_key_conditioner_key_debounce.sv | 127 ++++++++++++
 rtl/player_key_conditioner.sv | 106 ++++++++++
 tb/tb_player_key_conditioner.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_key_conditioner_pkg.sv
// Shared encodings for the key conditioner: arbiter states, debounce states,
// decision codes and the indices of the two player keys.
package player_key_conditioner_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ARMED   = 2'd1,
    ARB_DECIDED = 2'd2
  } arb_state_e;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_P1   = 2'b01;
  localparam logic [1:0] WHO_P2   = 2'b10;
  localparam logic [1:0] WHO_TIE  = 2'b11;

  localparam int NUM_KEYS = 4;
  localparam int P1_KEY   = 0;
  localparam int P2_KEY   = 3;

  function automatic logic [1:0] who_code(input logic p1, input logic p2);
    logic [1:0] code;
    unique case ({p2, p1})
      2'b01:   code = WHO_P1;
      2'b10:   code = WHO_P2;
      2'b11:   code = WHO_TIE;
      default: code = WHO_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/player_key_conditioner_key_debounce.sv
// One pushbutton: synchroniser, tick-based debounce, press pulse and, when
// KEYCOND_STUCK_DETECT_EN is defined, a saturating held-too-long flag.
module key_debounce
  import player_key_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_MS = 10,
  parameter int STUCK_MS    = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic stuck
);

  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   pressed_s;

  // Raw active-low sample enters at bit 0; the oldest stage is inverted to 1 = pressed.
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], key_n};
  assign pressed_s = ~sync_q[SYNC_STAGES-1];
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    unique case (state_q)
      DB_STABLE: begin
        if (pressed_s != level_q) begin
          state_d = DB_PENDING;
          cnt_d   = '0;
        end
      end
      DB_PENDING: begin
        if (pressed_s == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (ms_tick) begin
          if (cnt_inc == CNT_LAST) begin
            level_d = ~level_q;
            press_d = ~level_q;
            cnt_d   = '0;
            state_d = DB_STABLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign key_level = level_q;
  assign key_press = press_q;

`ifdef KEYCOND_STUCK_DETECT_EN
  localparam int SCNT_W = $clog2(STUCK_MS + 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STUCK_MS);

  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [SCNT_W-1:0] scnt_inc;
  logic              stuck_q, stuck_d;

  assign scnt_inc = scnt_q + SCNT_W'(1);

  // Counts only ticks after the level has risen; clears on the edge the level falls.
  always_comb begin
    scnt_d  = scnt_q;
    stuck_d = stuck_q;
    if (!level_d) begin
      scnt_d  = '0;
      stuck_d = 1'b0;
    end else if (level_q && ms_tick && (scnt_q != SCNT_LAST)) begin
      scnt_d = scnt_inc;
      if (scnt_inc == SCNT_LAST) stuck_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q  <= '0;
      stuck_q <= 1'b0;
    end else begin
      scnt_q  <= scnt_d;
      stuck_q <= stuck_d;
    end
  end

  assign stuck = stuck_q;
`else
  wire unused_stuck_cfg = (STUCK_MS > 0);
  assign stuck = 1'b0;
`endif

endmodule

// File: rtl/player_key_conditioner.sv
// Four-key conditioner with first-press arbitration between keys 0 and 3.
// Optional stuck-key detection is built when KEYCOND_STUCK_DETECT_EN is defined.
module player_key_conditioner
  import player_key_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_MS = 10,
  parameter int STUCK_MS    = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ms_tick,
  input  logic [3:0] key_n,
  input  logic       arm,
  input  logic       clear,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic       first_valid,
  output logic [1:0] first_who,
  output logic [3:0] stuck
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  // Assertion is immediate; release is retimed to clk before reaching the rest of the block.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .STUCK_MS   (STUCK_MS)
    ) u_key (
      .clk      (clk),
      .rst_n    (rst_n_int),
      .ms_tick  (ms_tick),
      .key_n    (key_n[i]),
      .key_level(key_level[i]),
      .key_press(key_press[i]),
      .stuck    (stuck[i])
    );
  end

  arb_state_e arb_q, arb_d;
  logic       valid_q, valid_d;
  logic [1:0] who_q, who_d;
  logic       p1_hit, p2_hit;

  assign p1_hit = key_press[P1_KEY] & ~stuck[P1_KEY];
  assign p2_hit = key_press[P2_KEY] & ~stuck[P2_KEY];

  always_comb begin
    arb_d   = arb_q;
    valid_d = valid_q;
    who_d   = who_q;
    if (clear) begin
      arb_d   = ARB_IDLE;
      valid_d = 1'b0;
      who_d   = WHO_NONE;
    end else begin
      unique case (arb_q)
        ARB_IDLE: begin
          if (arm) arb_d = ARB_ARMED;
        end
        ARB_ARMED: begin
          if (p1_hit || p2_hit) begin
            arb_d   = ARB_DECIDED;
            valid_d = 1'b1;
            who_d   = who_code(p1_hit, p2_hit);
          end else if (!arm) begin
            arb_d = ARB_IDLE;
          end
        end
        ARB_DECIDED: ;
        default: begin
          arb_d   = ARB_IDLE;
          valid_d = 1'b0;
          who_d   = WHO_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      arb_q   <= ARB_IDLE;
      valid_q <= 1'b0;
      who_q   <= WHO_NONE;
    end else begin
      arb_q   <= arb_d;
      valid_q <= valid_d;
      who_q   <= who_d;
    end
  end

  assign first_valid = valid_q;
  assign first_who   = who_q;

endmodule

// File: tb/tb_player_key_conditioner.sv
// Bench for player_key_conditioner: timestamp-based reference model checked every
// cycle, a table of arbitration cases, and hand-written reset/bounce sequences.
module tb_player_key_conditioner;

  localparam int SYNC = 2;
  localparam int DMS  = 10;
  localparam int SMS  = 20;
  localparam int TP   = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ms_tick = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       arm = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] key_level, key_press, stuck;
  logic       first_valid;
  logic [1:0] first_who;

  always #5 clk = ~clk;

  player_key_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_MS(DMS),
    .STUCK_MS   (SMS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ms_tick    (ms_tick),
    .key_n      (key_n),
    .arm        (arm),
    .clear      (clear),
    .key_level  (key_level),
    .key_press  (key_press),
    .first_valid(first_valid),
    .first_who  (first_who),
    .stuck      (stuck)
  );

  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  bit         use_model = 1'b1;
  logic [3:0] cur_kn = 4'hF;
  logic       cur_arm = 1'b0;

  // Reference model: keys are described by timestamps (tick count at the start of a
  // differing run / at the last rise), not by a state machine.
  logic [3:0] hist[$];
  int         tcount;
  logic [3:0] m_level, m_press, m_stuck;
  bit         run_on[4];
  int         run_base[4];
  int         rise_base[4];
  bit         m_open, m_dec;
  logic [1:0] m_who;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(4'hF);
    tcount  = 0;
    m_level = '0;
    m_press = '0;
    m_stuck = '0;
    for (int i = 0; i < 4; i++) begin
      run_on[i]    = 1'b0;
      run_base[i]  = 0;
      rise_base[i] = 0;
    end
    m_open = 1'b0;
    m_dec  = 1'b0;
    m_who  = 2'b00;
  endfunction

  function automatic void model_step(input logic [3:0] kn, input logic tk,
                                     input logic a, input logic c);
    logic [3:0] s, np;
    logic       p1, p2;
    s = ~hist.pop_front();
    hist.push_back(kn);
    if (tk) tcount++;
    p1 = m_press[0] & ~m_stuck[0];
    p2 = m_press[3] & ~m_stuck[3];
    if (c) begin
      m_open = 1'b0; m_dec = 1'b0; m_who = 2'b00;
    end else if (m_dec) begin
      m_dec = 1'b1;
    end else if (m_open) begin
      if (p1 || p2) begin
        m_dec = 1'b1; m_who = {p2, p1}; m_open = 1'b0;
      end else if (!a) begin
        m_open = 1'b0;
      end
    end else if (a) begin
      m_open = 1'b1;
    end
    np = '0;
    for (int i = 0; i < 4; i++) begin
      if (!run_on[i]) begin
        if (s[i] != m_level[i]) begin
          run_on[i]   = 1'b1;
          run_base[i] = tcount;
        end
      end else if (s[i] == m_level[i]) begin
        run_on[i] = 1'b0;
      end else if (tcount - run_base[i] == DMS) begin
        m_level[i] = ~m_level[i];
        np[i]      = m_level[i];
        run_on[i]  = 1'b0;
        if (m_level[i]) rise_base[i] = tcount;
      end
    end
    m_press = np;
`ifdef KEYCOND_STUCK_DETECT_EN
    for (int i = 0; i < 4; i++) m_stuck[i] = m_level[i] && (tcount - rise_base[i] >= SMS);
`else
    m_stuck = '0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic tick_cycle(input logic [3:0] kn, input logic a, input logic c);
    logic tk;
    tk = (cyc % TP == TP - 1);
    @(negedge clk);
    key_n = kn; ms_tick = tk; arm = a; clear = c;
    cur_kn = kn; cur_arm = a;
    @(posedge clk);
    if (use_model) model_step(kn, tk, a, c);
    #1;
    cyc++;
    if (use_model)
      check("model", 32'({key_level, key_press, first_valid, first_who, stuck}),
            32'({m_level, m_press, m_dec, m_who, m_stuck}));
  endtask

  task automatic run(input logic [3:0] kn, input logic a, input int n);
    for (int i = 0; i < n; i++) tick_cycle(kn, a, 1'b0);
  endtask

  task automatic align();
    while (cyc % TP != 0) tick_cycle(cur_kn, cur_arm, 1'b0);
  endtask

  task automatic wait_press(input string name, input int k, input logic [3:0] kn, input logic a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick_cycle(kn, a, 1'b0);
      if (key_press[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [3:0] kn;
    logic       a;
    logic [3:0] exp_level;
    logic       exp_valid;
    logic [1:0] exp_who;
  } arb_vec_t;

  arb_vec_t tv[6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  ticks;
    int  pw;
    bit  seen;
    bit  press_seen;
    logic [3:0] rkn;
    logic       ra;
    int         len;

    tv[0] = '{4'b1110, 1'b1, 4'b0001, 1'b1, 2'b01};
    tv[1] = '{4'b0111, 1'b1, 4'b1000, 1'b1, 2'b10};
    tv[2] = '{4'b0110, 1'b1, 4'b1001, 1'b1, 2'b11};
    tv[3] = '{4'b1001, 1'b1, 4'b0110, 1'b0, 2'b00};
    tv[4] = '{4'b1110, 1'b0, 4'b0001, 1'b0, 2'b00};
    tv[5] = '{4'b1011, 1'b1, 4'b0100, 1'b0, 2'b00};

    model_reset();
    run(4'hF, 1'b0, 4);
    check("reset_state", 32'({key_level, key_press, first_valid, first_who, stuck}), 32'd0);
    reset_n = 1'b1;

    // Test 1: idle for 50 ms
    press_seen = 1'b0;
    for (int i = 0; i < 50 * TP; i++) begin
      tick_cycle(4'hF, 1'b0, 1'b0);
      if (key_press != 4'b0) press_seen = 1'b1;
    end
    check("t1_level", 32'(key_level), 32'd0);
    check("t1_no_press", 32'(press_seen), 32'd0);
    check("t1_who", 32'(first_who), 32'd0);

    // Test 2: key 0 bounces on a 3 ms period, then settles low
    align();
    for (int b = 0; b < 6; b++) run((b % 2 == 0) ? 4'b1110 : 4'b1111, 1'b0, 3 * TP);
    ticks = 0; seen = 1'b0; pw = 0;
    for (int i = 0; i < 200; i++) begin
      if (cyc % TP == TP - 1) ticks++;
      tick_cycle(4'b1110, 1'b0, 1'b0);
      if (key_level[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("t2_rise_seen", 32'(seen), 32'd1);
    check("t2_ticks_to_rise", 32'(ticks), 32'(DMS));
    for (int i = 0; i < 4; i++) begin
      if (key_press[0]) pw++;
      tick_cycle(4'b1110, 1'b0, 1'b0);
    end
    check("t2_press_width", 32'(pw), 32'd1);
    run(4'hF, 1'b0, 14 * TP);

    // Table of arbitration cases
    for (int v = 0; v < 6; v++) begin
      tick_cycle(4'hF, 1'b0, 1'b1);
      run(tv[v].kn, tv[v].a, 14 * TP);
      check("tv_level", 32'(key_level), 32'(tv[v].exp_level));
      check("tv_valid", 32'(first_valid), 32'(tv[v].exp_valid));
      check("tv_who", 32'(first_who), 32'(tv[v].exp_who));
      run(4'hF, 1'b0, 14 * TP);
      tick_cycle(4'hF, 1'b0, 1'b1);
    end

    // Test 3: player 2 first, player 1 five ms later
    run(4'hF, 1'b1, 2);
    wait_press("t3_p2_press", 3, 4'b0111, 1'b1);
    tick_cycle(4'b0111, 1'b1, 1'b0);
    check("t3_decision", 32'({first_valid, first_who}), 32'b110);
    run(4'b0111, 1'b1, 5 * TP);
    wait_press("t3_p1_press", 0, 4'b0110, 1'b1);
    tick_cycle(4'b0110, 1'b1, 1'b0);
    check("t3_held", 32'({first_valid, first_who}), 32'b110);
    run(4'hF, 1'b0, 14 * TP);
    tick_cycle(4'hF, 1'b0, 1'b1);

    // Test 4: simultaneous press gives a tie
    run(4'hF, 1'b1, 2);
    wait_press("t4_p1_press", 0, 4'b0110, 1'b1);
    check("t4_coincide", 32'(key_press[3]), 32'd1);
    tick_cycle(4'b0110, 1'b1, 1'b0);
    check("t4_tie", 32'({first_valid, first_who}), 32'b111);

    // Test 5: clear coincident with a fresh key 0 press
    run(4'hF, 1'b1, 14 * TP);
    check("t5_still_held", 32'({first_valid, first_who}), 32'b111);
    wait_press("t5_p1_press", 0, 4'b1110, 1'b1);
    tick_cycle(4'b1110, 1'b0, 1'b1);
    check("t5_cleared", 32'({first_valid, first_who}), 32'b000);
    run(4'b1110, 1'b0, 5);
    check("t5_stays_idle", 32'({first_valid, first_who}), 32'b000);
    run(4'hF, 1'b0, 14 * TP);

    // Randomized segments against the model
    while (cyc < 9000) begin
      rkn = 4'($urandom);
      ra  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 160);
      for (int i = 0; i < len; i++) tick_cycle(rkn, ra, ($urandom_range(0, 60) == 0));
    end
    tick_cycle(4'hF, 1'b0, 1'b1);
    run(4'hF, 1'b0, 14 * TP);

    // Test 6: asynchronous reset in the middle of a pending press
    run(4'b0111, 1'b0, 14 * TP);
    run(4'b0110, 1'b0, 30);
    check("t6_pre_level", 32'(key_level), 32'b1000);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_clear", 32'({key_level, key_press, first_valid, first_who, stuck}), 32'd0);
    use_model = 1'b0;
    run(4'b0110, 1'b0, 4);
    check("t6_in_reset", 32'({key_level, key_press, first_valid, first_who, stuck}), 32'd0);
    align();
    reset_n = 1'b1;
    ticks = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cyc % TP == TP - 1) ticks++;
      tick_cycle(4'b0110, 1'b0, 1'b0);
      if (key_level[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_rise_seen", 32'(seen), 32'd1);
    check("t6_ticks_to_rise", 32'(ticks), 32'(DMS));
    check("t6_press", 32'(key_press), 32'b1001);
`ifdef KEYCOND_STUCK_DETECT_EN
    ticks = 0; seen = 1'b0;
    for (int i = 0; i < 30 * TP; i++) begin
      if (cyc % TP == TP - 1) ticks++;
      tick_cycle(4'b0110, 1'b0, 1'b0);
      if (stuck[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_stuck_seen", 32'(seen), 32'd1);
    check("t6_stuck_ticks", 32'(ticks), 32'(SMS));
`else
    run(4'b0110, 1'b0, 25 * TP);
    check("t6_no_stuck", 32'(stuck), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
